bp_me_cce_perf_mon: RTL

BP_ME_CCE_PERF_MON -- requirements
Module: bp_me_cce_perf_mon

---
 rtl/bp_me_cce_perf_mon.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/bp_me_cce_perf_mon.sv
// CCE performance monitor: tracks in-flight requests by LCE ID and accumulates
// per-op latency statistics plus global event counters behind a read port.
module bp_me_cce_perf_mon
  #(parameter int slots_p        = 4
   ,parameter int lce_id_width_p = 3
   ,parameter int cnt_width_p    = 32
   ,parameter int lat_width_p    = 16
   )
  (input  logic                             clk_i
  ,input  logic                             reset_n_i
  ,input  logic                             clear_i
  ,input  logic                             start_v_i
  ,input  logic [lce_id_width_p-1:0]        start_lce_i
  ,input  logic [1:0]                       start_op_i
  ,input  logic                             end_v_i
  ,input  logic [lce_id_width_p-1:0]        end_lce_i
  ,input  logic                             rd_v_i
  ,input  logic [4:0]                       rd_addr_i
  ,output logic                             rd_v_o
  ,output logic [cnt_width_p-1:0]           rd_data_o
  ,output logic [$clog2(slots_p+1)-1:0]     occupancy_o
  ,output logic                             full_o
  );

  localparam int occ_width_lp = $clog2(slots_p+1);
  localparam int idx_width_lp = (slots_p > 1) ? $clog2(slots_p) : 1;

  function automatic logic [cnt_width_p-1:0] sat_add(input logic [cnt_width_p-1:0] a,
                                                     input logic [cnt_width_p-1:0] b);
    logic [cnt_width_p:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[cnt_width_p] ? '1 : s[cnt_width_p-1:0];
  endfunction

  function automatic logic [lat_width_p-1:0] lat_inc(input logic [lat_width_p-1:0] a);
    return (a == '1) ? a : a + lat_width_p'(1);
  endfunction

  logic [slots_p-1:0]        valid_q;
  logic [lce_id_width_p-1:0] lce_q [slots_p];
  logic [1:0]                op_q  [slots_p];
  logic [lat_width_p-1:0]    lat_q [slots_p];

  logic [cnt_width_p-1:0] cnt_q [4];
  logic [cnt_width_p-1:0] sum_q [4];
  logic [cnt_width_p-1:0] max_q [4];
  logic [cnt_width_p-1:0] min_q [4];
  logic [cnt_width_p-1:0] total_q, busy_q, drop_q, orphan_q, dup_q;

  logic [occ_width_lp-1:0] occ_q, occ_n;
  logic                    full_q, full_n;
  logic                    rd_v_q;
  logic [cnt_width_p-1:0]  rd_data_q, rd_mux;

  logic                    end_hit, retire, dup_hit, free_hit, alloc, dup_ev, drop_ev, orphan_ev;
  logic [idx_width_lp-1:0] end_idx, free_idx;
  logic [slots_p-1:0]      valid_post, valid_n;
  logic [lat_width_p-1:0]  retire_lat;
  logic [cnt_width_p-1:0]  retire_lat_ext;
  logic [1:0]              retire_op;

  // End matches pre-cycle slots; start sees the slot set after that retire.
  always_comb begin
    end_hit  = 1'b0;
    end_idx  = '0;
    dup_hit  = 1'b0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = slots_p-1; i >= 0; i--) begin
      if (valid_q[i] && (lce_q[i] == end_lce_i)) begin
        end_hit = 1'b1;
        end_idx = idx_width_lp'(i);
      end
    end
    retire    = end_v_i & end_hit;
    orphan_ev = end_v_i & ~end_hit;
    valid_post = valid_q;
    if (retire) valid_post[end_idx] = 1'b0;
    for (int i = slots_p-1; i >= 0; i--) begin
      if (valid_post[i] && (lce_q[i] == start_lce_i)) dup_hit = 1'b1;
      if (!valid_post[i]) begin
        free_hit = 1'b1;
        free_idx = idx_width_lp'(i);
      end
    end
    dup_ev  = start_v_i & dup_hit;
    alloc   = start_v_i & ~dup_hit & free_hit;
    drop_ev = start_v_i & ~dup_hit & ~free_hit;

    valid_n = valid_post;
    if (alloc) valid_n[free_idx] = 1'b1;
    if (clear_i) valid_n = '0;
    occ_n = '0;
    for (int i = 0; i < slots_p; i++) occ_n = occ_n + occ_width_lp'(valid_n[i]);
    full_n = (occ_n == occ_width_lp'(slots_p));

    retire_lat     = lat_inc(lat_q[end_idx]);
    retire_lat_ext = cnt_width_p'(retire_lat);
    retire_op      = op_q[end_idx];
  end

  always_comb begin
    rd_mux = '0;
    if (!rd_addr_i[4]) begin
      case (rd_addr_i[1:0])
        2'd0:    rd_mux = cnt_q[rd_addr_i[3:2]];
        2'd1:    rd_mux = sum_q[rd_addr_i[3:2]];
        2'd2:    rd_mux = max_q[rd_addr_i[3:2]];
        default: rd_mux = min_q[rd_addr_i[3:2]];
      endcase
    end else begin
      case (rd_addr_i)
        5'd16:   rd_mux = total_q;
        5'd17:   rd_mux = busy_q;
        5'd18:   rd_mux = drop_q;
        5'd19:   rd_mux = orphan_q;
        5'd20:   rd_mux = dup_q;
        5'd21:   rd_mux = cnt_width_p'(occ_q);
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < slots_p; i++) begin
        valid_q[i] <= 1'b0;
        lce_q[i]   <= '0;
        op_q[i]    <= '0;
        lat_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < slots_p; i++) begin
        if (clear_i) begin
          valid_q[i] <= 1'b0;
          lat_q[i]   <= '0;
        end else if (alloc && (free_idx == idx_width_lp'(i))) begin
          valid_q[i] <= 1'b1;
          lce_q[i]   <= start_lce_i;
          op_q[i]    <= start_op_i;
          lat_q[i]   <= '0;
        end else if (retire && (end_idx == idx_width_lp'(i))) begin
          valid_q[i] <= 1'b0;
        end else if (valid_q[i]) begin
          lat_q[i] <= lat_inc(lat_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
        sum_q[k] <= '0;
        max_q[k] <= '0;
        min_q[k] <= '1;
      end
      total_q  <= '0;
      busy_q   <= '0;
      drop_q   <= '0;
      orphan_q <= '0;
      dup_q    <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
        sum_q[k] <= '0;
        max_q[k] <= '0;
        min_q[k] <= '1;
      end
      total_q  <= '0;
      busy_q   <= '0;
      drop_q   <= '0;
      orphan_q <= '0;
      dup_q    <= '0;
    end else begin
      total_q <= sat_add(total_q, cnt_width_p'(1));
      if (occ_q != '0) busy_q   <= sat_add(busy_q,   cnt_width_p'(1));
      if (drop_ev)     drop_q   <= sat_add(drop_q,   cnt_width_p'(1));
      if (orphan_ev)   orphan_q <= sat_add(orphan_q, cnt_width_p'(1));
      if (dup_ev)      dup_q    <= sat_add(dup_q,    cnt_width_p'(1));
      if (retire) begin
        cnt_q[retire_op] <= sat_add(cnt_q[retire_op], cnt_width_p'(1));
        sum_q[retire_op] <= sat_add(sum_q[retire_op], retire_lat_ext);
        if (retire_lat_ext > max_q[retire_op]) max_q[retire_op] <= retire_lat_ext;
        if (retire_lat_ext < min_q[retire_op]) min_q[retire_op] <= retire_lat_ext;
      end
    end
  end

  // Read data is captured from pre-update state and held between reads.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
      occ_q     <= '0;
      full_q    <= 1'b0;
    end else begin
      rd_v_q <= rd_v_i;
      if (rd_v_i) rd_data_q <= rd_mux;
      occ_q  <= occ_n;
      full_q <= full_n;
    end
  end

  assign rd_v_o      = rd_v_q;
  assign rd_data_o   = rd_data_q;
  assign occupancy_o = occ_q;
  assign full_o      = full_q;

endmodule
